pi1_arb: RTL and testbench

- Parametrised N-master to 1-slave PerInt (pi1) arbiter.
- Replaces the single-master pass-through and the fixed queue used by the multi-PU wrapper.
- Adds selectable round-robin or fixed-priority arbitration, a bounded burst allowance per grant, and a grant vector for debug and simulation.
- Sits between the PU array and the memory/peripheral slave, all in a single clock domain.

---
 rtl/pi1_arb.sv | 162 ++++++++++++++++
 tb/tb_pi1_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi1_arb.sv
// pi1_arb: N-master to 1-slave PerInt arbiter.
// Round-robin or fixed-priority selection, bounded back-to-back burst per grant,
// one-hot grant vector for observation. Single clock domain.
module pi1_arb #(
    parameter int ARCHBITSZ = 16,
    parameter int MCOUNT    = 2,
    parameter int MODE      = 0,
    parameter int MAXBURST  = 1,
    localparam int SELBITSZ  = ARCHBITSZ / 8,
    localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                          rst_i,
    input  logic                          clk_i,
    input  logic [2*MCOUNT-1:0]           m_op_i,
    input  logic [ADDRBITSZ*MCOUNT-1:0]   m_addr_i,
    input  logic [ARCHBITSZ*MCOUNT-1:0]   m_data_i,
    output logic [ARCHBITSZ*MCOUNT-1:0]   m_data_o,
    input  logic [SELBITSZ*MCOUNT-1:0]    m_sel_i,
    output logic [MCOUNT-1:0]             m_rdy_o,
    output logic [1:0]                    s_op_o,
    output logic [ADDRBITSZ-1:0]          s_addr_o,
    output logic [ARCHBITSZ-1:0]          s_data_o,
    input  logic [ARCHBITSZ-1:0]          s_data_i,
    output logic [SELBITSZ-1:0]           s_sel_o,
    input  logic                          s_rdy_i,
    output logic [MCOUNT-1:0]             gnt_o
);

    localparam int IW = (MCOUNT > 1) ? $clog2(MCOUNT) : 1;
    localparam int BW = $clog2(MAXBURST) + 1;
    localparam logic [1:0] OP_NOOP = 2'd0;

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAITRSP = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  g_q, g_d;
    logic [IW-1:0]  last_q, last_d;
    logic [BW-1:0]  bcnt_q, bcnt_d;

    logic [1:0]           op_a   [MCOUNT];
    logic [ADDRBITSZ-1:0] addr_a [MCOUNT];
    logic [ARCHBITSZ-1:0] data_a [MCOUNT];
    logic [SELBITSZ-1:0]  sel_a  [MCOUNT];
    logic [MCOUNT-1:0]    req;

    // Split the flat per-master buses into indexable arrays.
    for (genvar gi = 0; gi < MCOUNT; gi++) begin : g_unpack
        assign op_a[gi]   = m_op_i[2*gi +: 2];
        assign addr_a[gi] = m_addr_i[ADDRBITSZ*gi +: ADDRBITSZ];
        assign data_a[gi] = m_data_i[ARCHBITSZ*gi +: ARCHBITSZ];
        assign sel_a[gi]  = m_sel_i[SELBITSZ*gi +: SELBITSZ];
        assign req[gi]    = (m_op_i[2*gi +: 2] != OP_NOOP);
    end

    logic [1:0] g_op;
    assign g_op = op_a[g_q];

    logic [IW-1:0] win;
    logic          found;

    // Winner selection: lowest index in fixed mode, otherwise first requester after last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        if (MODE == 1) begin
            for (int k = 0; k < MCOUNT; k++) begin
                if (!found && req[k]) begin
                    win   = IW'(k);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= MCOUNT; i++) begin
                for (int k = 0; k < MCOUNT; k++) begin
                    if (!found && req[k] && (((int'(last_q) + i) % MCOUNT) == k)) begin
                        win   = IW'(k);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            last_q  <= IW'(MCOUNT - 1);
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state logic: grant, acceptance, completion and burst limit.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    g_d     = win;
                    bcnt_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (g_op == OP_NOOP) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end else if (s_rdy_i) begin
                    state_d = WAITRSP;
                end
            end
            WAITRSP: begin
                if (s_rdy_i) begin
                    bcnt_d = bcnt_q + BW'(1);
                    if ((g_op != OP_NOOP) && ((int'(bcnt_q) + 1) < MAXBURST)) begin
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                        last_d  = g_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: slave sees the granted master only while in GRANT; others get zeros.
    always_comb begin
        s_op_o   = OP_NOOP;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        gnt_o    = '0;
        m_rdy_o  = '0;
        m_data_o = '0;
        if (state_q == GRANT) begin
            s_op_o   = g_op;
            s_addr_o = addr_a[g_q];
            s_data_o = data_a[g_q];
            s_sel_o  = sel_a[g_q];
        end
        for (int k = 0; k < MCOUNT; k++) begin
            if ((state_q != IDLE) && (g_q == IW'(k))) begin
                gnt_o[k]   = 1'b1;
                m_rdy_o[k] = s_rdy_i;
                if (state_q == WAITRSP) begin
                    m_data_o[ARCHBITSZ*k +: ARCHBITSZ] = s_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_pi1_arb.sv
// Bench for pi1_arb: three 4-master instances (RR burst 1, fixed priority, RR burst 3)
// share stimulus; a per-master model drives requests and a scoreboard holds the
// expected service order.
`timescale 1ns/1ps
module tb_pi1_arb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*N-1:0]  m_op   = '0;
    logic [AW*N-1:0] m_addr = '0;
    logic [DW*N-1:0] m_data = '0;
    logic [SW*N-1:0] m_sel  = '0;
    logic [DW-1:0]   s_din  = '0;
    logic            s_rdy  = 1'b1;

    logic [DW*N-1:0] md_o [3];
    logic [N-1:0]    mr_o [3];
    logic [1:0]      sop  [3];
    logic [AW-1:0]   sad  [3];
    logic [DW-1:0]   sdo  [3];
    logic [SW-1:0]   ssel [3];
    logic [N-1:0]    gnt  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        pi1_arb #(
            .ARCHBITSZ(DW), .MCOUNT(N),
            .MODE((gi == 1) ? 1 : 0),
            .MAXBURST((gi == 2) ? 3 : 1)
        ) u_dut (
            .rst_i(rst), .clk_i(clk),
            .m_op_i(m_op), .m_addr_i(m_addr), .m_data_i(m_data), .m_data_o(md_o[gi]),
            .m_sel_i(m_sel), .m_rdy_o(mr_o[gi]),
            .s_op_o(sop[gi]), .s_addr_o(sad[gi]), .s_data_o(sdo[gi]), .s_data_i(s_din),
            .s_sel_o(ssel[gi]), .s_rdy_i(s_rdy), .gnt_o(gnt[gi])
        );
    end

    typedef struct packed {
        logic [3:0]    m;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } txn_t;

    txn_t       mq     [N][$];
    txn_t       shadow [N][$];
    txn_t       exp_q  [$];
    int         phase  [N];
    int         done_cnt [N];
    logic       rdy_sched [$];
    logic [N-1:0] gnt_log [$];
    logic [1:0]   sop_log [$];
    logic [N-1:0] mrdy_log [$];
    logic [AW-1:0] slave_addr = '0;
    int sel = 0;
    int total = 0;
    int bad = 0;

    function automatic logic [DW-1:0] rdata_of(logic [AW-1:0] a);
        return {a, 1'b1} ^ 16'hBEEF;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            shadow[k].delete();
            phase[k] = 0;
            done_cnt[k] = 0;
        end
        exp_q.delete();
        rdy_sched.delete();
        gnt_log.delete();
        sop_log.delete();
        mrdy_log.delete();
    endtask

    task automatic do_reset(int s);
        sel = s;
        rst = 1'b1;
        m_op = '0;
        s_rdy = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(int k, logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
        txn_t t;
        t.m = 4'(k); t.op = op; t.addr = a; t.data = d; t.sel = s;
        mq[k].push_back(t);
        shadow[k].push_back(t);
        if (phase[k] == 0) phase[k] = 1;
    endtask

    task automatic expect_next(int k);
        exp_q.push_back(shadow[k].pop_front());
    endtask

    // Master model: hold the head op until accepted, then present the next op (if any)
    // while waiting for completion.
    task automatic drive();
        m_op = '0; m_addr = '0; m_data = '0; m_sel = '0;
        for (int k = 0; k < N; k++) begin
            txn_t t;
            logic drv;
            t = '0;
            drv = 1'b0;
            if (phase[k] == 1) begin
                t = mq[k][0]; drv = 1'b1;
            end else if (phase[k] == 2 && mq[k].size() > 1) begin
                t = mq[k][1]; drv = 1'b1;
            end
            if (drv) begin
                m_op[2*k +: 2]    = t.op;
                m_addr[AW*k +: AW] = t.addr;
                m_data[DW*k +: DW] = t.data;
                m_sel[SW*k +: SW]  = t.sel;
            end
        end
        s_rdy = (rdy_sched.size() > 0) ? rdy_sched.pop_front() : 1'b1;
        s_din = rdata_of(slave_addr);
    endtask

    task automatic observe();
        logic [N-1:0] mr;
        logic [N-1:0] idle_mask;
        mr = mr_o[sel];
        idle_mask = '0;
        gnt_log.push_back(gnt[sel]);
        sop_log.push_back(sop[sel]);
        mrdy_log.push_back(mr);
        for (int k = 0; k < N; k++) idle_mask[k] = (phase[k] == 0);
        check("rdy_stray", 64'(mr & idle_mask), 64'd0);
        for (int k = 0; k < N; k++) begin
            if (mr[k] && phase[k] == 1) begin
                txn_t e;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("acc_master", 64'(k), 64'(e.m));
                check("acc_gnt", 64'(gnt[sel]), 64'(4'b0001 << k));
                check("acc_op", 64'(sop[sel]), 64'(e.op));
                check("acc_addr", 64'(sad[sel]), 64'(e.addr));
                check("acc_wdata", 64'(sdo[sel]), 64'(e.data));
                check("acc_sel", 64'(ssel[sel]), 64'(e.sel));
                slave_addr = sad[sel];
                phase[k] = 2;
            end else if (mr[k] && phase[k] == 2) begin
                txn_t t;
                logic [DW*N-1:0] mask;
                t = mq[k].pop_front();
                mask = ~({{(DW*(N-1)){1'b0}}, {DW{1'b1}}} << (DW*k));
                if (t.op[1]) check("rd_data", 64'(md_o[sel][DW*k +: DW]), 64'(rdata_of(t.addr)));
                check("md_other_zero", md_o[sel] & mask, 64'd0);
                done_cnt[k]++;
                $display("txn dut=%0d m=%0d op=%0d addr=%h wdata=%h", sel, k, t.op, t.addr, t.data);
                phase[k] = (mq[k].size() > 0) ? 1 : 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1 drive();
        @(negedge clk);
        observe();
    endtask

    function automatic logic busy();
        logic b;
        b = (exp_q.size() > 0);
        for (int k = 0; k < N; k++) if (mq[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(int maxc);
        int c;
        c = 0;
        while (busy() && c < maxc) begin
            step();
            c++;
        end
        check("drained", 64'(busy()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with requests present.
        m_op = 8'hFF;
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_sop", 64'(sop[i]), 64'd0);
            check("rst_gnt", 64'(gnt[i]), 64'd0);
            check("rst_mrdy", 64'(mr_o[i]), 64'd0);
        end

        // Single read: 1-cycle grant latency, 1-cycle slave op, then idle.
        do_reset(0);
        issue(0, 2'd2, 15'h0010, 16'h0000, 2'b11);
        expect_next(0);
        drain(20);
        step();
        check("sr_gnt_c0", 64'(gnt_log[0]), 64'd0);
        check("sr_gnt_c1", 64'(gnt_log[1]), 64'd1);
        check("sr_sop_c1", 64'(sop_log[1]), 64'd2);
        check("sr_gnt_c2", 64'(gnt_log[2]), 64'd1);
        check("sr_sop_c2", 64'(sop_log[2]), 64'd0);
        check("sr_gnt_c3", 64'(gnt_log[3]), 64'd0);

        // Round-robin fairness, MAXBURST 1.
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            issue(0, (i % 2 == 0) ? 2'd2 : 2'd3, 15'(16'h0100 + i), 16'(16'hA000 + i), 2'b01);
            issue(1, (i % 2 == 0) ? 2'd1 : 2'd2, 15'(16'h0200 + i), 16'(16'hB000 + i), 2'b10);
        end
        for (int i = 0; i < 4; i++) begin
            expect_next(0);
            expect_next(1);
        end
        drain(200);
        check("rr_done_m0", 64'(done_cnt[0]), 64'd4);
        check("rr_done_m1", 64'(done_cnt[1]), 64'd4);

        // Fixed priority: M1 is served fully before M3.
        do_reset(1);
        for (int i = 0; i < 3; i++) issue(1, 2'd2, 15'(16'h0310 + i), 16'h0000, 2'b11);
        for (int i = 0; i < 2; i++) issue(3, 2'd1, 15'(16'h0330 + i), 16'(16'hC300 + i), 2'b11);
        expect_next(1); expect_next(1); expect_next(1);
        expect_next(3); expect_next(3);
        drain(200);
        check("fp_done_m3", 64'(done_cnt[3]), 64'd2);

        // Burst of 3, then the other master, then the remaining 2.
        do_reset(2);
        for (int i = 0; i < 5; i++) issue(0, 2'd1, 15'(16'h0400 + i), 16'(16'hD000 + i), 2'b01);
        issue(1, 2'd2, 15'h0500, 16'h0000, 2'b11);
        expect_next(0); expect_next(0); expect_next(0);
        expect_next(1);
        expect_next(0); expect_next(0);
        drain(200);
        for (int i = 1; i <= 6; i++) check("bu_gnt_burst1", 64'(gnt_log[i]), 64'd1);
        check("bu_gnt_idle", 64'(gnt_log[7]), 64'd0);
        check("bu_gnt_m1", 64'(gnt_log[8]), 64'd2);
        for (int i = 11; i <= 14; i++) check("bu_gnt_burst2", 64'(gnt_log[i]), 64'd1);

        // Slave stall of 5 cycles in WAITRSP.
        do_reset(0);
        rdy_sched = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        issue(2, 2'd2, 15'h0022, 16'h0000, 2'b11);
        expect_next(2);
        drain(50);
        for (int i = 2; i <= 6; i++) begin
            check("st_sop", 64'(sop_log[i]), 64'd0);
            check("st_gnt", 64'(gnt_log[i]), 64'd4);
            check("st_mrdy", 64'(mrdy_log[i]), 64'd0);
        end
        check("st_mrdy_done", 64'(mrdy_log[7]), 64'd4);

        // Reset in WAITRSP: outputs clear without a clock edge; last pointer restored.
        do_reset(0);
        issue(0, 2'd1, 15'h0600, 16'h1234, 2'b11);
        expect_next(0);
        drain(20);
        rdy_sched = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        issue(1, 2'd2, 15'h0610, 16'h0000, 2'b11);
        expect_next(1);
        repeat (3) step();
        check("rm_gnt_before", 64'(gnt[sel]), 64'd2);
        #1 rst = 1'b1;
        #1;
        check("rm_sop", 64'(sop[sel]), 64'd0);
        check("rm_gnt", 64'(gnt[sel]), 64'd0);
        check("rm_mrdy", 64'(mr_o[sel]), 64'd0);
        clear_model();
        m_op = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1, 2'd2, 15'h0620, 16'h0000, 2'b11);
        issue(0, 2'd2, 15'h0630, 16'h0000, 2'b11);
        expect_next(0);
        expect_next(1);
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
